// File: rtl/vga_text_scan.sv
// 80x48 text-mode VGA scanner: raster counters, char RAM / glyph ROM fetch,
// five-stage pixel pipeline with a blinking underline cursor.
module vga_text_scan #(
  parameter int H_VIS     = 640,
  parameter int H_FP      = 16,
  parameter int H_SW      = 96,
  parameter int H_BP      = 48,
  parameter int V_VIS     = 480,
  parameter int V_FP      = 10,
  parameter int V_SW      = 2,
  parameter int V_BP      = 33,
  parameter int BLINK_BIT = 5
) (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] str_out,
  input  logic [7:0]  ram_q,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_q,
  input  logic [6:0]  count_str,
  input  logic [5:0]  count_tab,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        pixel,
  output logic        frame_start
);

  localparam logic [9:0] H_END  = 10'(H_VIS);
  localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SW);
  localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SW + H_BP - 1);
  localparam logic [9:0] V_END  = 10'(V_VIS);
  localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SW);
  localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SW + V_BP - 1);

  // sync flags travel active-high so an all-zero reset means "no sync"
  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic       cur;
    logic [2:0] x;
  } meta_t;

  logic [9:0]  hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic [3:0]  line_q, line_d;
  logic [5:0]  row_q, row_d;
  logic [5:0]  fcnt_q;
  logic [6:0]  col;
  logic [11:0] addr;
  logic        blink;
  logic        fs_d;
  logic        px_d;
  meta_t       m0, s1_q, s2_q, s3_q, s4_q;
  logic [3:0]  line1_q, line2_q;
  logic        blank3_q, blank4_q;

  always_comb begin
    hcnt_d = hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    line_d = line_q;
    row_d  = row_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      if (vcnt_q == V_LAST) begin
        vcnt_d = '0;
        line_d = '0;
        row_d  = '0;
      end else begin
        vcnt_d = vcnt_q + 10'd1;
        if (line_q == 4'd9) begin
          line_d = '0;
          row_d  = row_q + 6'd1;
        end else begin
          line_d = line_q + 4'd1;
        end
      end
    end
  end

  assign col   = hcnt_q[9:3];
  assign addr  = {row_q, 6'b0} + {2'b0, row_q, 4'b0} + {5'b0, col};
  assign blink = fcnt_q[BLINK_BIT];
  assign fs_d  = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);

  always_comb begin
    m0     = '0;
    m0.de  = (hcnt_q < H_END) && (vcnt_q < V_END);
    m0.hs  = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
    m0.vs  = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
    m0.cur = blink && (line_q == 4'd9) &&
             (col == count_str) && (row_q == count_tab);
    m0.x   = hcnt_q[2:0];
  end

  always_comb begin
    px_d = 1'b0;
    if (s4_q.de) begin
      px_d = (~blank4_q & font_q[3'd7 - s4_q.x]) ^ s4_q.cur;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      line_q      <= '0;
      row_q       <= '0;
      fcnt_q      <= '0;
      frame_start <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      s4_q        <= '0;
      line1_q     <= '0;
      line2_q     <= '0;
      blank3_q    <= 1'b0;
      blank4_q    <= 1'b0;
      str_out     <= '0;
      font_addr   <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      pixel       <= 1'b0;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      line_q      <= line_d;
      row_q       <= row_d;
      frame_start <= fs_d;
      if (frame_start) begin
        fcnt_q <= fcnt_q + 6'd1;
      end
      s1_q      <= m0;
      line1_q   <= line_q;
      str_out   <= addr;
      s2_q      <= s1_q;
      line2_q   <= line1_q;
      s3_q      <= s2_q;
      font_addr <= {ram_q, line2_q};
      blank3_q  <= (ram_q == 8'h00);
      s4_q      <= s3_q;
      blank4_q  <= blank3_q;
      hsync     <= ~s4_q.hs;
      vsync     <= ~s4_q.vs;
      de        <= s4_q.de;
      pixel     <= px_d;
    end
  end

endmodule

// File: tb/tb_vga_text_scan.sv
// Bench for vga_text_scan: per-cycle scoreboard against a raster model,
// a table of raster spot checks and hand-written timing sequences.
module tb_vga_text_scan;

  localparam int HV  = 640;
  localparam int HT  = 800;
  localparam int VV  = 20;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 2;
  localparam int VT  = VV + VFP + VSW + VBP;
  localparam int BB  = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] str_out, font_addr;
  logic [7:0]  ram_q, font_q;
  logic [6:0]  count_str;
  logic [5:0]  count_tab;
  logic        hsync, vsync, de, pixel, frame_start;

  vga_text_scan #(
    .H_VIS(HV), .V_VIS(VV), .V_FP(VFP), .V_SW(VSW), .V_BP(VBP),
    .BLINK_BIT(BB)
  ) dut (
    .clk(clk), .rst(rst), .str_out(str_out), .ram_q(ram_q),
    .font_addr(font_addr), .font_q(font_q),
    .count_str(count_str), .count_tab(count_tab),
    .hsync(hsync), .vsync(vsync), .de(de), .pixel(pixel),
    .frame_start(frame_start)
  );

  always #20 clk = ~clk;

  logic [7:0] ram [4096];
  logic [7:0] font[4096];

  always @(posedge clk) begin
    ram_q  <= ram[str_out];
    font_q <= font[font_addr];
  end

  int cmp_n = 0;
  int err_n = 0;

  task automatic check(input string nm, input int act, input int exp);
    cmp_n++;
    if (act != exp) begin
      err_n++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // raster reference model
  int   h_m, v_m, fc_m, cyc;
  logic fs_m;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_m  <= 0;
      v_m  <= 0;
      fc_m <= 0;
      fs_m <= 1'b0;
      cyc  <= 0;
    end else begin
      cyc  <= cyc + 1;
      fs_m <= (h_m == 0 && v_m == 0);
      if (h_m == 0 && v_m == 0) fc_m <= fc_m + 1;
      if (h_m == HT - 1) begin
        h_m <= 0;
        v_m <= (v_m == VT - 1) ? 0 : v_m + 1;
      end else begin
        h_m <= h_m + 1;
      end
    end
  end

  typedef struct {
    logic hs;
    logic vs;
    logic de;
    logic px;
  } out_t;

  out_t sb[$];
  out_t e;

  function automatic out_t model(input int h, input int v, input int fc);
    out_t o;
    int ln, rw, col, a, code;
    logic [7:0] g;
    logic cur, px;
    ln   = v % 10;
    rw   = v / 10;
    col  = h / 8;
    a    = (rw * 80 + col) % 4096;
    code = ram[a];
    cur  = fc[BB] && ln == 9 && col == count_str && rw == count_tab;
    g    = font[(code * 16 + ln) % 4096];
    px   = (code != 0) ? g[7 - (h % 8)] : 1'b0;
    o.de = (h < HV) && (v < VV);
    o.hs = !(h >= HV + 16 && h < HV + 112);
    o.vs = !(v >= VV + VFP && v < VV + VFP + VSW);
    o.px = o.de & (px ^ cur);
    return o;
  endfunction

  // expectation pushed for the current S0 position, popped 5 cycles on
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
    end else begin
      if (sb.size() == 0) begin
        repeat (5) sb.push_back('{1'b1, 1'b1, 1'b0, 1'b0});
      end
      sb.push_back(model(h_m, v_m, fc_m));
      e = sb.pop_front();
      check("sb_hs_vs_de_px", {hsync, vsync, de, pixel},
            {e.hs, e.vs, e.de, e.px});
      check("frame_start", frame_start, fs_m);
    end
  end

  task automatic wait_pos(input int h, input int v);
    for (int i = 0; i < 2 * VT * HT; i++) begin
      @(negedge clk);
      if (h_m == h && v_m == v) return;
    end
    check("wait_pos_timeout", 0, 1);
  endtask

  task automatic wait_sig(input string nm, input int which,
                          input logic lvl, input int budget);
    logic s;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      s = (which == 0) ? hsync : (which == 1) ? vsync : frame_start;
      if (s == lvl) return;
    end
    check({nm, "_timeout"}, 0, 1);
  endtask

  task automatic cursor_chk(input string nm, input logic lvl);
    wait_pos(40, 19);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      check(nm, {de, pixel}, {1'b1, lvl});
    end
  endtask

  typedef struct {
    int h;
    int v;
    int addr;
    int ln;
    logic de;
    logic hs;
    logic vs;
  } vec_t;

  vec_t vt[10];
  int   t0;
  logic [7:0] a5;

  initial begin
    vt[0] = '{639, 0,  79, 0, 1'b1, 1'b1, 1'b1};
    vt[1] = '{648, 0,  81, 0, 1'b0, 1'b1, 1'b1};
    vt[2] = '{656, 0,  82, 0, 1'b0, 1'b0, 1'b1};
    vt[3] = '{700, 0,  87, 0, 1'b0, 1'b0, 1'b1};
    vt[4] = '{752, 0,  94, 0, 1'b0, 1'b1, 1'b1};
    vt[5] = '{0,   20, 160, 0, 1'b0, 1'b1, 1'b1};
    vt[6] = '{100, 22, 172, 2, 1'b0, 1'b1, 1'b0};
    vt[7] = '{100, 23, 172, 3, 1'b0, 1'b1, 1'b0};
    vt[8] = '{24,  25, 163, 5, 1'b0, 1'b1, 1'b1};
    vt[9] = '{0,   0,  0,   0, 1'b1, 1'b1, 1'b1};

    for (int i = 0; i < 4096; i++) begin
      ram[i]  = (i % 4 == 1) ? 8'h00 : 8'(i ^ 8'h5A);
      font[i] = 8'(i * 7 + (i >> 4));
    end
    ram[0]     = 8'h41;
    font[1040] = 8'hA5;
    a5         = 8'hA5;
    count_str  = 7'd5;
    count_tab  = 6'd1;

    #3 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outs", {hsync, vsync, de, pixel, frame_start}, 5'b11000);
    check("rst_str_out", str_out, 0);
    check("rst_font_addr", font_addr, 0);

    @(posedge clk);
    #5 rst = 1'b1;

    // 'A' glyph row 0 in the top-left cell
    wait_pos(0, 0);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      check("glyph_px", {de, pixel}, {1'b1, a5[7 - i]});
    end

    wait_sig("hs_fall", 0, 1'b0, 2000);
    check("hs_fall_cyc", cyc, 661);
    t0 = cyc;
    wait_sig("hs_rise", 0, 1'b1, 200);
    check("hs_low_len", cyc - t0, 96);
    wait_sig("hs_fall2", 0, 1'b0, 1000);
    check("hs_period", cyc - t0, 800);

    cursor_chk("cursor_on", 1'b1);

    wait_sig("vs_fall", 1, 1'b0, VT * HT);
    check("vs_fall_cyc", cyc, (VV + VFP) * HT + 5);
    t0 = cyc;
    wait_sig("vs_rise", 1, 1'b1, 4000);
    check("vs_low_len", cyc - t0, 1600);

    wait_sig("fs_next", 2, 1'b1, VT * HT);
    check("fs_period", cyc - 1, VT * HT);

    for (int i = 0; i < 10; i++) begin
      if (i == 5) cursor_chk("cursor_off", 1'b0);
      wait_pos(vt[i].h, vt[i].v);
      @(negedge clk);
      check("vec_str_out", str_out, vt[i].addr);
      repeat (2) @(negedge clk);
      check("vec_font_addr", font_addr, ram[vt[i].addr] * 16 + vt[i].ln);
      repeat (2) @(negedge clk);
      check("vec_hs_vs_de", {hsync, vsync, de},
            {vt[i].hs, vt[i].vs, vt[i].de});
    end

    // asynchronous reset mid-frame
    wait_pos(300, 10);
    check("pre_rst_de", de, 1);
    #5 rst = 1'b0;
    #1;
    check("async_rst_outs", {hsync, vsync, de, pixel, frame_start},
          5'b11000);
    check("async_rst_str_out", str_out, 0);
    repeat (2) @(posedge clk);
    #5 rst = 1'b1;
    wait_sig("hs_fall_rst", 0, 1'b0, 2000);
    check("hs_fall_after_rst", cyc, 661);
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
